reg_chain_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for a shared two-stage register transfer chain (hold -> stage A -> stage C).
- NREQ requesters compete for the chain. The winner's data is captured, then shifted A then C under FSM control.
- All chain registers update with non-blocking semantics on clk. No same-edge read/write race is permitted between stages.
- Sits between requester blocks and any consumer of stage_c.

---
 rtl/reg_chain_arbiter.sv | 108 ++++++++++
 tb/tb_reg_chain_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_chain_arbiter.sv
// Round-robin arbiter driving a hold -> stage A -> stage C register chain; one transfer per 3 cycles.
// gnt after the request edge, stage_a +1, stage_c/ack +2; requesters stall by holding req until ack.
module reg_chain_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      stage_a,
  output logic [DW-1:0]      stage_c,
  output logic               busy,
  output logic [IDW-1:0]     last_id
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD_A = 2'd1;
  localparam logic [1:0] S_LOAD_C = 2'd2;

  logic [1:0]      r_state;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_win;
  logic [IDW-1:0]  r_last_id;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_ack;
  logic [DW-1:0]   r_hold;
  logic [DW-1:0]   r_stage_a;
  logic [DW-1:0]   r_stage_c;

  logic            w_any;
  logic [IDW-1:0]  w_win;
  logic [IDW-1:0]  w_idx;
  logic [NREQ-1:0] w_onehot;
  logic [IDW-1:0]  w_ptr_next;

  // Scan from the farthest offset down so the closest set bit after ptr wins.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_idx = IDW'((int'(r_ptr) + i) % NREQ);
      if (req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign w_onehot   = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
  assign w_ptr_next = (int'(r_win) == NREQ - 1) ? '0 : r_win + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_win     <= '0;
      r_last_id <= '0;
      r_gnt     <= '0;
      r_ack     <= '0;
      r_hold    <= '0;
      r_stage_a <= '0;
      r_stage_c <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_onehot;
            r_hold  <= wdata[int'(w_win)*DW +: DW];
            r_win   <= w_win;
            r_state <= S_LOAD_A;
          end else begin
            r_gnt <= '0;
          end
        end
        S_LOAD_A: begin
          r_stage_a <= r_hold;
          r_state   <= S_LOAD_C;
        end
        S_LOAD_C: begin
          r_stage_c <= r_stage_a;
          r_ack     <= r_gnt;
          r_gnt     <= '0;
          r_last_id <= r_win;
          r_ptr     <= w_ptr_next;
          r_state   <= S_IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign ack     = r_ack;
  assign stage_a = r_stage_a;
  assign stage_c = r_stage_c;
  assign busy    = (r_state != S_IDLE);
  assign last_id = r_last_id;

endmodule

// File: tb/tb_reg_chain_arbiter.sv
// Directed bench for reg_chain_arbiter: reset, single transfer, fairness, skip/wrap, early drop, mid-transfer reset.
module tb_reg_chain_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [3:0]  stage_a;
  logic [3:0]  stage_c;
  logic        busy;
  logic [1:0]  last_id;

  int n_checks = 0;
  int n_errors = 0;

  reg_chain_arbiter #(.NREQ(4), .DW(4), .IDW(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .wdata   (wdata),
    .gnt     (gnt),
    .ack     (ack),
    .stage_a (stage_a),
    .stage_c (stage_c),
    .busy    (busy),
    .last_id (last_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req   = 4'b1111;
    wdata = 16'h4321;
    tick();
    tick();
    n_checks += 6;
    if (gnt !== 4'b0000) begin n_errors++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
    if (ack !== 4'b0000) begin n_errors++; $display("FAIL reset_ack got=%b want=0000", ack); end
    if (stage_a !== 4'h0) begin n_errors++; $display("FAIL reset_stage_a got=%h want=0", stage_a); end
    if (stage_c !== 4'h0) begin n_errors++; $display("FAIL reset_stage_c got=%h want=0", stage_c); end
    if (last_id !== 2'd0) begin n_errors++; $display("FAIL reset_last_id got=%0d want=0", last_id); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (gnt !== 4'b0001) begin n_errors++; $display("FAIL reset_first_gnt got=%b want=0001", gnt); end
    tick();
    tick();
    n_checks++;
    if (stage_c !== 4'h1) begin n_errors++; $display("FAIL reset_first_data got=%h want=1", stage_c); end
    req = 4'b0000;
    tick();
  endtask

  // ptr=1 on entry
  task automatic test_single;
    req   = 4'b0010;
    wdata = 16'h0090;
    tick();
    n_checks += 2;
    if (gnt !== 4'b0010) begin n_errors++; $display("FAIL single_gnt got=%b want=0010", gnt); end
    if (busy !== 1'b1) begin n_errors++; $display("FAIL single_busy got=%b want=1", busy); end
    tick();
    n_checks++;
    if (stage_a !== 4'h9) begin n_errors++; $display("FAIL single_stage_a got=%h want=9", stage_a); end
    tick();
    n_checks += 4;
    if (stage_c !== 4'h9) begin n_errors++; $display("FAIL single_stage_c got=%h want=9", stage_c); end
    if (ack !== 4'b0010) begin n_errors++; $display("FAIL single_ack got=%b want=0010", ack); end
    if (last_id !== 2'd1) begin n_errors++; $display("FAIL single_last_id got=%0d want=1", last_id); end
    if (gnt !== 4'b0000) begin n_errors++; $display("FAIL single_gnt_clear got=%b want=0000", gnt); end
    req = 4'b0000;
    tick();
    n_checks += 2;
    if (ack !== 4'b0000) begin n_errors++; $display("FAIL single_ack_clear got=%b want=0000", ack); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL single_idle got=%b want=0", busy); end
  endtask

  task automatic test_fairness;
    logic [3:0] exp_data [4];
    exp_data[0] = 4'hA; exp_data[1] = 4'hB; exp_data[2] = 4'hC; exp_data[3] = 4'hD;
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    rst_n = 1'b1;
    req   = 4'b1111;
    wdata = 16'hDCBA;
    for (int n = 0; n < 5; n++) begin
      tick();
      n_checks++;
      if (gnt !== (4'b0001 << (n % 4)))
        begin n_errors++; $display("FAIL fair_gnt%0d got=%b want=%b", n, gnt, 4'b0001 << (n % 4)); end
      tick();
      tick();
      n_checks += 2;
      if (stage_c !== exp_data[n % 4])
        begin n_errors++; $display("FAIL fair_data%0d got=%h want=%h", n, stage_c, exp_data[n % 4]); end
      if (ack !== (4'b0001 << (n % 4)))
        begin n_errors++; $display("FAIL fair_ack%0d got=%b want=%b", n, ack, 4'b0001 << (n % 4)); end
    end
    req = 4'b0000;
    tick();
  endtask

  // ptr=1 on entry
  task automatic test_skip_wrap;
    logic [3:0] exp_gnt [3];
    logic [3:0] exp_dat [3];
    exp_gnt[0] = 4'b0100; exp_gnt[1] = 4'b0001; exp_gnt[2] = 4'b0100;
    exp_dat[0] = 4'h5;    exp_dat[1] = 4'h2;    exp_dat[2] = 4'h5;
    req   = 4'b0101;
    wdata = 16'h0502;
    for (int n = 0; n < 3; n++) begin
      tick();
      n_checks++;
      if (gnt !== exp_gnt[n]) begin n_errors++; $display("FAIL skip_gnt%0d got=%b want=%b", n, gnt, exp_gnt[n]); end
      tick();
      tick();
      n_checks += 2;
      if (ack !== exp_gnt[n]) begin n_errors++; $display("FAIL skip_ack%0d got=%b want=%b", n, ack, exp_gnt[n]); end
      if (stage_c !== exp_dat[n]) begin n_errors++; $display("FAIL skip_data%0d got=%h want=%h", n, stage_c, exp_dat[n]); end
    end
    req = 4'b0000;
    tick();
  endtask

  // ptr=3 on entry
  task automatic test_early_drop;
    req   = 4'b0001;
    wdata = 16'h0003;
    tick();
    n_checks++;
    if (gnt !== 4'b0001) begin n_errors++; $display("FAIL drop_gnt got=%b want=0001", gnt); end
    req   = 4'b0000;
    wdata = 16'h000F;
    tick();
    n_checks++;
    if (stage_a !== 4'h3) begin n_errors++; $display("FAIL drop_stage_a got=%h want=3", stage_a); end
    tick();
    n_checks += 2;
    if (stage_c !== 4'h3) begin n_errors++; $display("FAIL drop_stage_c got=%h want=3", stage_c); end
    if (ack !== 4'b0001) begin n_errors++; $display("FAIL drop_ack got=%b want=0001", ack); end
    tick();
    n_checks++;
    if (ack !== 4'b0000) begin n_errors++; $display("FAIL drop_ack_clear got=%b want=0000", ack); end
  endtask

  // ptr=1 on entry
  task automatic test_mid_reset;
    req   = 4'b0100;
    wdata = 16'h0700;
    tick();
    n_checks++;
    if (gnt !== 4'b0100) begin n_errors++; $display("FAIL mid_gnt got=%b want=0100", gnt); end
    rst_n = 1'b0;
    tick();
    n_checks += 6;
    if (gnt !== 4'b0000) begin n_errors++; $display("FAIL mid_gnt_clear got=%b want=0000", gnt); end
    if (ack !== 4'b0000) begin n_errors++; $display("FAIL mid_ack got=%b want=0000", ack); end
    if (stage_a !== 4'h0) begin n_errors++; $display("FAIL mid_stage_a got=%h want=0", stage_a); end
    if (stage_c !== 4'h0) begin n_errors++; $display("FAIL mid_stage_c got=%h want=0", stage_c); end
    if (last_id !== 2'd0) begin n_errors++; $display("FAIL mid_last_id got=%0d want=0", last_id); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL mid_busy got=%b want=0", busy); end
    rst_n = 1'b1;
    req   = 4'b0000;
    tick();
    tick();
    n_checks += 2;
    if (ack !== 4'b0000) begin n_errors++; $display("FAIL mid_no_ack got=%b want=0000", ack); end
    if (stage_c !== 4'h0) begin n_errors++; $display("FAIL mid_no_data got=%h want=0", stage_c); end
    req   = 4'b1111;
    wdata = 16'h4321;
    tick();
    n_checks++;
    if (gnt !== 4'b0001) begin n_errors++; $display("FAIL mid_ptr_gnt got=%b want=0001", gnt); end
    tick();
    tick();
    n_checks += 2;
    if (ack !== 4'b0001) begin n_errors++; $display("FAIL mid_ptr_ack got=%b want=0001", ack); end
    if (stage_c !== 4'h1) begin n_errors++; $display("FAIL mid_ptr_data got=%h want=1", stage_c); end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    wdata = 16'h0000;
    test_reset();
    test_single();
    test_fairness();
    test_skip_wrap();
    test_early_drop();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
